// File: rtl/g_shl32_seq_if.sv
// Handshake/data bundle for the iterative 32-bit left shifter.
// master drives requests and operands; slave (the shifter) returns result and status.
interface g_shl32_seq_if;
  logic        Start;
  logic [31:0] In;
  logic [4:0]  Sa;
  logic        Rot;
  logic [31:0] Out;
  logic        Carry;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, In, Sa, Rot,
    input  Out, Carry, Busy, Done
  );

  modport slave (
    input  Start, In, Sa, Rot,
    output Out, Carry, Busy, Done
  );
endinterface

// File: rtl/g_shl32_seq.sv
// Iterative 32-bit left shifter: two bit positions per cycle, one on an odd remainder.
// Optional rotate-left support is compiled in with G_SHL32_ROTATE_EN.
module g_shl32_seq (
  input  logic          clk,
  input  logic          rst_n,
  g_shl32_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] out_q;
  logic        carry_q;
  logic [4:0]  rem_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] out_d;
  logic        carry_d;
  logic [4:0]  rem_d;
  logic [1:0]  fill2;
  logic        fill1;

`ifdef G_SHL32_ROTATE_EN
  logic rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if ((state_q != ST_SHIFT) && bus.Start) begin
      rot_q <= bus.Rot;
    end
  end

  // Bits leaving the MSB end re-enter at the LSB end.
  assign fill2 = rot_q ? out_q[31:30] : 2'b00;
  assign fill1 = rot_q ? out_q[31]    : 1'b0;
`else
  assign fill2 = 2'b00;
  assign fill1 = 1'b0;
`endif

  // One shift step; carry is always the last bit pushed past bit 31.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    if (rem_q >= 5'd2) begin
      out_d   = {out_q[29:0], fill2};
      carry_d = out_q[30];
      rem_d   = rem_q - 5'd2;
    end else if (rem_q == 5'd1) begin
      out_d   = {out_q[30:0], fill1};
      carry_d = out_q[31];
      rem_d   = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= 32'h0;
      carry_q <= 1'b0;
      rem_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          out_q   <= out_d;
          carry_q <= carry_d;
          rem_q   <= rem_d;
          if (rem_d == 5'd0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (bus.Start) begin
            out_q   <= bus.In;
            rem_q   <= bus.Sa;
            carry_q <= 1'b0;
            if (bus.Sa != 5'd0) begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.Out   = out_q;
  assign bus.Carry = carry_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_g_shl32_seq.sv
// Directed, table-driven bench for g_shl32_seq with hand-computed expectations.
// Rotate expectations switch on G_SHL32_ROTATE_EN.
module tb_g_shl32_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  g_shl32_seq_if bus ();

  g_shl32_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] in_v;
    logic [4:0]  sa;
    logic        rot;
    logic [31:0] exp_log;
    logic [31:0] exp_rot;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] lg, input logic [31:0] rt, input logic rot);
`ifdef G_SHL32_ROTATE_EN
    return rot ? rt : lg;
`else
    return (rot && 1'b0) ? rt : lg;
`endif
  endfunction

  // Drive a request now (between edges); returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] in_v, input logic [4:0] sa, input logic rot);
    bus.Start = 1'b1;
    bus.In    = in_v;
    bus.Sa    = sa;
    bus.Rot   = rot;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.In    = $urandom;
    bus.Sa    = 5'($urandom);
    bus.Rot   = 1'($urandom);
  endtask

  // Bounded wait for Done; counts edges after the accepting edge and Busy cycles.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!bus.Done && lat < 40) begin
      if (bus.Busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] exp_out, input logic exp_carry,
                              input int exp_lat, input int lat, input int busy_cnt);
    chk({name, ".done"},  32'(bus.Done), 32'd1);
    chk({name, ".out"},   bus.Out, exp_out);
    chk({name, ".carry"}, 32'(bus.Carry), 32'(exp_carry));
    chk({name, ".lat"},   32'(lat), 32'(exp_lat));
    chk({name, ".busy"},  32'(busy_cnt), 32'(exp_lat));
    chk({name, ".busy_in_done"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int lat, bcnt, seen;
    logic [31:0] e;

    vecs[0]  = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[1]  = '{32'hF000_000F, 5'd4,  1'b0, 32'h0000_00F0, 32'h0000_00F0, 1'b1};
    vecs[2]  = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[3]  = '{32'hA5A5_A5A5, 5'd1,  1'b0, 32'h4B4B_4B4A, 32'h4B4B_4B4A, 1'b1};
    vecs[4]  = '{32'hA5A5_A5A5, 5'd2,  1'b0, 32'h9696_9694, 32'h9696_9694, 1'b0};
    vecs[5]  = '{32'h0000_FFFF, 5'd16, 1'b0, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0};
    vecs[6]  = '{32'h0001_8000, 5'd16, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1};
    vecs[7]  = '{32'h1234_5678, 5'd7,  1'b0, 32'h1A2B_3C00, 32'h1A2B_3C00, 1'b1};
    vecs[8]  = '{32'h8000_0001, 5'd3,  1'b1, 32'h0000_0008, 32'h0000_000C, 1'b0};
    vecs[9]  = '{32'hF000_000F, 5'd4,  1'b1, 32'h0000_00F0, 32'h0000_00FF, 1'b1};
    vecs[10] = '{32'hA5A5_A5A5, 5'd1,  1'b1, 32'h4B4B_4B4A, 32'h4B4B_4B4B, 1'b1};
    vecs[11] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};

    // Reset with random inputs, including Start.
    bus.Start = 1'($urandom);
    bus.In    = $urandom;
    bus.Sa    = 5'($urandom);
    bus.Rot   = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("reset.state", {bus.Out[31:0]}, 32'h0);
    chk("reset.flags", {29'd0, bus.Carry, bus.Busy, bus.Done}, 32'h0);
    bus.Start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle.hold", bus.Out | {29'd0, bus.Carry, bus.Busy, bus.Done}, 32'h0);
    end

    // Table-driven single operations, each followed by a check that Done drops.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].in_v, vecs[i].sa, vecs[i].rot);
      wait_done(lat, bcnt);
      e = pick(vecs[i].exp_log, vecs[i].exp_rot, vecs[i].rot);
      check_result($sformatf("vec%0d", i), e, vecs[i].exp_carry, (int'(vecs[i].sa) + 1) / 2, lat, bcnt);
      $display("vec%0d in=%h sa=%0d rot=%0d out=%h carry=%0d lat=%0d", i, vecs[i].in_v, vecs[i].sa,
               vecs[i].rot, bus.Out, bus.Carry, lat);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.pulse", i), 32'(bus.Done), 32'd0);
      chk($sformatf("vec%0d.hold", i), bus.Out, e);
    end

    // Back-to-back: new Start accepted in the DONE cycle.
    issue(32'hF000_000F, 5'd4, 1'b0);
    wait_done(lat, bcnt);
    check_result("b2b.first", 32'h0000_00F0, 1'b1, 2, lat, bcnt);
    issue(32'h1234_5678, 5'd0, 1'b0);
    wait_done(lat, bcnt);
    check_result("b2b.second", 32'h1234_5678, 1'b0, 0, lat, bcnt);
    $display("b2b out=%h carry=%0d lat=%0d", bus.Out, bus.Carry, lat);
    @(posedge clk);
    #1;

    // Start during SHIFT must be ignored.
    issue(32'h0000_00A5, 5'd9, 1'b0);
    @(posedge clk);
    #1;
    bus.Start = 1'b1;
    bus.In    = 32'hFFFF_FFFF;
    bus.Sa    = 5'd1;
    bus.Rot   = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    wait_done(lat, bcnt);
    check_result("ignore", 32'h0001_4A00, 1'b0, 5, lat + 2, bcnt + 2);
    $display("ignore out=%h carry=%0d lat=%0d", bus.Out, bus.Carry, lat + 2);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a long operation.
    issue(32'h0000_0003, 5'd20, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("midrst.busy_before", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.out", bus.Out, 32'h0);
    chk("midrst.flags", {29'd0, bus.Carry, bus.Busy, bus.Done}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done || bus.Busy) seen++;
    end
    chk("midrst.no_done", 32'(seen), 32'd0);
    $display("midrst out=%h busy=%0d done=%0d", bus.Out, bus.Busy, bus.Done);
    issue(32'h0000_0003, 5'd20, 1'b0);
    wait_done(lat, bcnt);
    check_result("after_rst", 32'h0030_0000, 1'b0, 10, lat, bcnt);
    $display("after_rst out=%h carry=%0d lat=%0d", bus.Out, bus.Carry, lat);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
